// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the ID-stage branch controller: opcode constants,
// forwarding-select encoding, FSM states and the control-transfer decoder.
package branch_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [4:0] RI_BLTZ   = 5'h00;
  localparam logic [4:0] RI_BGEZ   = 5'h01;
  localparam logic [4:0] RI_BLTZAL = 5'h10;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_DSLOT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_JREG = 2'd3
  } br_kind_e;

  typedef struct packed {
    br_kind_e kind;
    logic     use_rs;
    logic     use_rt;
  } br_dec_t;

  // Classify an instruction and report which source registers it compares.
  function automatic br_dec_t br_decode(input logic [XLEN-1:0] instr);
    br_dec_t d;
    d.kind   = BR_NONE;
    d.use_rs = 1'b0;
    d.use_rt = 1'b0;
    case (instr[31:26])
      OP_REGIMM: begin
        if (instr[20:16] == RI_BLTZ || instr[20:16] == RI_BGEZ ||
            instr[20:16] == RI_BLTZAL || instr[20:16] == RI_BGEZAL) begin
          d.kind   = BR_COND;
          d.use_rs = 1'b1;
        end
      end
      OP_BEQ, OP_BNE: begin
        d.kind   = BR_COND;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        d.kind   = BR_COND;
        d.use_rs = 1'b1;
      end
      OP_J, OP_JAL: d.kind = BR_JUMP;
      OP_SPECIAL: begin
        if (instr[5:0] == FN_JR || instr[5:0] == FN_JALR) begin
          d.kind   = BR_JREG;
          d.use_rs = 1'b1;
        end
      end
      default: d.kind = BR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_ctrl_branch_target.sv
// Combinational redirect-target calculation for branches, jumps and register jumps.
module branch_target
  import branch_ctrl_pkg::*;
(
  input  br_kind_e          kind,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   instr,
  input  logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   target
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;

  assign pc4    = pc + XLEN'(4);
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    target = '0;
    case (kind)
      BR_COND: target = pc4 + br_off;
      BR_JUMP: target = {pc4[31:28], instr[25:0], 2'b00};
      BR_JREG: target = op_a;
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: hazard stalls, compare forwarding, redirect and delay slot.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       op_a,
  input  logic              cmp_taken,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wr_reg,
  input  logic              mem_wr_en,
  input  logic              mem_is_load,
  input  logic [4:0]        mem_wr_reg,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_stalls
);

  localparam int unsigned LOAD_CNT = (LOAD_STALL > 1) ? LOAD_STALL : 1;
  localparam int unsigned STALL_W  = $clog2(LOAD_CNT + 1);

  state_e             state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               resolve;

  br_dec_t            dec;
  logic [REG_W-1:0]   rs, rt;
  logic [XLEN-1:0]    target;
  logic               ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic               hz_load, hz_one;

  assign dec = br_decode(id_instr);
  assign rs  = id_instr[25:21];
  assign rt  = id_instr[20:16];

  // Register 0 is hardwired and never creates a dependency.
  assign ex_hit_a  = dec.use_rs && (rs != '0) && ex_wr_en  && (ex_wr_reg  == rs);
  assign ex_hit_b  = dec.use_rt && (rt != '0) && ex_wr_en  && (ex_wr_reg  == rt);
  assign mem_hit_a = dec.use_rs && (rs != '0) && mem_wr_en && (mem_wr_reg == rs);
  assign mem_hit_b = dec.use_rt && (rt != '0) && mem_wr_en && (mem_wr_reg == rt);

  assign hz_load = (ex_hit_a || ex_hit_b) && ex_is_load;
  assign hz_one  = ((ex_hit_a || ex_hit_b) && !ex_is_load) ||
                   ((mem_hit_a || mem_hit_b) && mem_is_load);

  branch_target u_target (
    .kind   (dec.kind),
    .pc     (id_pc),
    .instr  (id_instr),
    .op_a   (op_a),
    .target (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational so a branch resolves in the cycle it sits in ID.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall          = 1'b0;
    fwd_a_sel      = FWD_RF;
    fwd_b_sel      = FWD_RF;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resolve        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (id_valid && dec.kind != BR_NONE) begin
          if (hz_load) begin
            state_d = ST_STALL;
            cnt_d   = STALL_W'(LOAD_CNT);
          end else if (hz_one) begin
            state_d = ST_STALL;
            cnt_d   = STALL_W'(1);
          end else begin
            resolve        = 1'b1;
            fwd_a_sel      = (mem_hit_a && !mem_is_load) ? FWD_MEM : FWD_RF;
            fwd_b_sel      = (mem_hit_b && !mem_is_load) ? FWD_MEM : FWD_RF;
            redirect_valid = cmp_taken;
            redirect_pc    = cmp_taken ? target : '0;
            state_d        = ST_DSLOT;
          end
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        if (cnt_q <= STALL_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_W'(1);
        end
      end
      ST_DSLOT: begin
        if (id_valid) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      stall          = 1'b0;
      fwd_a_sel      = FWD_RF;
      fwd_b_sel      = FWD_RF;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      resolve        = 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] n_branches_q, n_taken_q, n_stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_branches_q <= '0;
      n_taken_q    <= '0;
      n_stalls_q   <= '0;
    end else begin
      if (resolve)        n_branches_q <= n_branches_q + CNT_W'(1);
      if (redirect_valid) n_taken_q    <= n_taken_q + CNT_W'(1);
      if (stall)          n_stalls_q   <= n_stalls_q + CNT_W'(1);
    end
  end

  assign stat_branches = n_branches_q;
  assign stat_taken    = n_taken_q;
  assign stat_stalls   = n_stalls_q;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
  assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; stats expectations follow BRANCH_STATS_EN.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, op_a;
  logic        cmp_taken;
  logic        ex_wr_en, ex_is_load, mem_wr_en, mem_is_load;
  logic [4:0]  ex_wr_reg, mem_wr_reg;
  logic        stall, redirect_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_taken, stat_stalls;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JR4 = {6'h00, 5'd4, 5'd0, 5'd0, 5'd0, 6'h08};
  localparam logic [31:0] ADD = {6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20};

`ifdef BRANCH_STATS_EN
  localparam int EXP_BR = 7, EXP_TK = 5, EXP_ST = 5;
`else
  localparam int EXP_BR = 0, EXP_TK = 0, EXP_ST = 0;
`endif

  always #5 clk = ~clk;

  branch_ctrl #(.LOAD_STALL(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .op_a(op_a), .cmp_taken(cmp_taken),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_reg(ex_wr_reg),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_reg(mem_wr_reg),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stalls(stat_stalls)
  );

  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] a, input logic tk);
    id_valid = v; id_instr = ins; id_pc = pc; op_a = a; cmp_taken = tk;
  endtask

  task automatic haz(input logic exw, input logic exl, input logic [4:0] exr,
                     input logic mw, input logic ml, input logic [4:0] mr);
    ex_wr_en = exw; ex_is_load = exl; ex_wr_reg = exr;
    mem_wr_en = mw; mem_is_load = ml; mem_wr_reg = mr;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, NOP, 32'h0, 32'h0, 1'b0);
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_tk", stat_taken, 32'd0);
    chk("rst_stat_st", stat_stalls, 32'd0);
    cyc();
    reset = 1'b0;

    // BEQ taken, no hazard
    drv(1'b1, ity(6'h04, 5'd1, 5'd2, 16'h0004), 32'h100, 32'h0, 1'b1);
    @(negedge clk);
    chk("beq_rv", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h0000_0114);
    chk("beq_stall", 32'(stall), 32'd0);
    cyc();
    drv(1'b1, ity(6'h04, 5'd1, 5'd2, 16'h0004), 32'h104, 32'h0, 1'b1);
    @(negedge clk);
    chk("beq_dslot_rv", 32'(redirect_valid), 32'd0);
    cyc();

    // BNE with load in EX on rs
    drv(1'b1, ity(6'h05, 5'd5, 5'd6, 16'h0010), 32'h300, 32'h0, 1'b1);
    haz(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("bne_detect_rv", 32'(redirect_valid), 32'd0);
    chk("bne_detect_stall", 32'(stall), 32'd0);
    cyc();
    haz(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd5);
    @(negedge clk);
    chk("bne_stall1", 32'(stall), 32'd1);
    cyc();
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("bne_stall2", 32'(stall), 32'd1);
    chk("bne_stall2_rv", 32'(redirect_valid), 32'd0);
    cyc();
    drv(1'b1, ity(6'h05, 5'd5, 5'd6, 16'h0010), 32'h300, 32'h0, 1'b0);
    @(negedge clk);
    chk("bne_res_stall", 32'(stall), 32'd0);
    chk("bne_res_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("bne_res_rv", 32'(redirect_valid), 32'd0);
    cyc();
    drv(1'b0, NOP, 32'h304, 32'h0, 1'b0);
    @(negedge clk);
    chk("dslot_idle_rv", 32'(redirect_valid), 32'd0);
    cyc();
    drv(1'b1, ity(6'h04, 5'd1, 5'd2, 16'h0004), 32'h400, 32'h0, 1'b1);
    @(negedge clk);
    chk("dslot_hold_rv", 32'(redirect_valid), 32'd0);
    cyc();

    // BGTZ with ALU write in EX, then MEM forward
    drv(1'b1, ity(6'h07, 5'd3, 5'd0, 16'hFFFF), 32'h200, 32'h0, 1'b1);
    haz(1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("bgtz_detect_rv", 32'(redirect_valid), 32'd0);
    cyc();
    haz(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3);
    @(negedge clk);
    chk("bgtz_stall", 32'(stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("bgtz_res_stall", 32'(stall), 32'd0);
    chk("bgtz_fwd_a", 32'(fwd_a_sel), 32'd2);
    chk("bgtz_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("bgtz_rv", 32'(redirect_valid), 32'd1);
    chk("bgtz_pc", redirect_pc, 32'h0000_0200);
    cyc();
    drv(1'b1, NOP, 32'h204, 32'h0, 1'b0);
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc();

    // JR and a branch in its delay slot
    drv(1'b1, JR4, 32'h500, 32'h8000_0040, 1'b1);
    @(negedge clk);
    chk("jr_rv", 32'(redirect_valid), 32'd1);
    chk("jr_pc", redirect_pc, 32'h8000_0040);
    cyc();
    drv(1'b1, ity(6'h05, 5'd1, 5'd2, 16'h0008), 32'h504, 32'h0, 1'b1);
    @(negedge clk);
    chk("jr_dslot_rv", 32'(redirect_valid), 32'd0);
    chk("jr_dslot_stall", 32'(stall), 32'd0);
    cyc();

    // J keeps the upper PC nibble of pc+4
    drv(1'b1, {6'h02, 26'h000_0100}, 32'hF000_0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("j_rv", 32'(redirect_valid), 32'd1);
    chk("j_pc", redirect_pc, 32'hF000_0400);
    chk("j_fwd_a", 32'(fwd_a_sel), 32'd0);
    cyc();
    drv(1'b1, NOP, 32'hF000_0004, 32'h0, 1'b0);
    cyc();

    // non-branch with a hazard, and invalid ID in IDLE
    drv(1'b1, ADD, 32'h600, 32'h0, 1'b1);
    haz(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("add_stall", 32'(stall), 32'd0);
    chk("add_rv", 32'(redirect_valid), 32'd0);
    cyc();
    drv(1'b0, ity(6'h04, 5'd1, 5'd2, 16'h0004), 32'h604, 32'h0, 1'b1);
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("invalid_rv", 32'(redirect_valid), 32'd0);
    chk("invalid_stall", 32'(stall), 32'd0);
    cyc();

    // EX load on rs and MEM load on rt: longer stall wins
    drv(1'b1, ity(6'h04, 5'd1, 5'd2, 16'h0008), 32'h700, 32'h0, 1'b0);
    haz(1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd2);
    @(negedge clk);
    chk("both_detect_stall", 32'(stall), 32'd0);
    cyc();
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("both_stall1", 32'(stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("both_stall2", 32'(stall), 32'd1);
    cyc();
    @(negedge clk);
    chk("both_res_stall", 32'(stall), 32'd0);
    chk("both_res_rv", 32'(redirect_valid), 32'd0);
    chk("both_res_fwd_b", 32'(fwd_b_sel), 32'd0);
    cyc();
    drv(1'b1, ity(6'h04, 5'd1, 5'd2, 16'h0004), 32'h704, 32'h0, 1'b1);
    @(negedge clk);
    chk("both_dslot_rv", 32'(redirect_valid), 32'd0);
    cyc();

    // register 0 never hazards
    drv(1'b1, ity(6'h04, 5'd0, 5'd0, 16'h0002), 32'h800, 32'h0, 1'b1);
    haz(1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
    @(negedge clk);
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_rv", 32'(redirect_valid), 32'd1);
    chk("r0_pc", redirect_pc, 32'h0000_080C);
    cyc();
    drv(1'b1, NOP, 32'h804, 32'h0, 1'b0);
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    cyc();
    @(negedge clk);
    chk("stat_branches", stat_branches, 32'(EXP_BR));
    chk("stat_taken", stat_taken, 32'(EXP_TK));
    chk("stat_stalls", stat_stalls, 32'(EXP_ST));
    cyc();

    // reset asserted in the middle of a stall
    drv(1'b1, ity(6'h04, 5'd5, 5'd6, 16'h0004), 32'h900, 32'h0, 1'b1);
    haz(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
    cyc();
    haz(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_rv", 32'(redirect_valid), 32'd0);
    chk("mid_rst_pc", redirect_pc, 32'd0);
    chk("mid_rst_stat_br", stat_branches, 32'd0);
    chk("mid_rst_stat_st", stat_stalls, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rv", 32'(redirect_valid), 32'd1);
    chk("post_rst_pc", redirect_pc, 32'h0000_0914);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 2: stall cycles for a branch whose source is a load in EX.
REQ-002 SHALL have parameter CNT_W, default 32: width of statistics counters.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_instr  in  32  instruction in ID
- id_pc  in  32  PC of the ID instruction
- op_a  in  32  forwarded rs value (JR/JALR target)
- cmp_taken  in  1  quick-compare branch/jump taken result for id_instr
- ex_wr_en, ex_is_load  in  1 each  EX stage writes a register / is a load
- ex_wr_reg  in  5  EX destination
- mem_wr_en, mem_is_load  in  1 each  MEM stage writes a register / is a load
- mem_wr_reg  in  5  MEM destination
- stall  out  1  hold IF and ID, insert a bubble into EX
- fwd_a_sel, fwd_b_sel  out  2 each  compare operand source: 00 regfile, 01 EX result, 10 MEM result
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  redirect target
- stat_branches, stat_taken, stat_stalls  out  CNT_W each  statistics

Function
REQ-004 SHALL decode control transfers: REGIMM (BLTZ/BGEZ/BLTZAL/BGEZAL), BEQ, BNE, BLEZ, BGTZ, J, JAL, JR, JALR; all other instructions are non-branches.
REQ-005 SHALL define sources as rs for every branch; rs and rt for BEQ/BNE; rs for JR/JALR; none for J/JAL. Register 0 SHALL never cause a hazard.
REQ-006 SHALL implement FSM states IDLE, STALL, DSLOT.
REQ-007 IDLE, valid branch, source matches EX dest, EX is load: SHALL go to STALL with counter = LOAD_STALL.
REQ-008 IDLE, valid branch, source matches EX dest (non-load), or source matches MEM dest and MEM is load: SHALL go to STALL with counter = 1.
REQ-009 If REQ-007 and REQ-008 both apply, the larger count SHALL win.
REQ-010 STALL SHALL assert stall and decrement the counter each cycle; at counter 1 the next state SHALL be IDLE, where hazards are re-evaluated.
REQ-011 IDLE, branch, no hazard: SHALL set each fwd_*_sel to 10 when the source matches a non-load MEM dest, else 00; SHALL resolve in the same cycle.
REQ-012 On resolve with cmp_taken=1: SHALL pulse redirect_valid for exactly one cycle and go to DSLOT.
REQ-013 On resolve with cmp_taken=0: SHALL produce no redirect and go to DSLOT.
REQ-014 redirect_pc SHALL be:
- branches: id_pc+4+(sign-extended imm16<<2), modulo 2^32
- J/JAL: {(id_pc+4)[31:28], instr[25:0], 00}
- JR/JALR: op_a
REQ-015 DSLOT: the next valid ID instruction is the delay slot; a branch there SHALL be ignored (no stall, no redirect). Then go to IDLE. id_valid=0 SHALL hold DSLOT.
REQ-016 id_valid=0 in IDLE SHALL produce no stall and no redirect.
REQ-017 fwd_*_sel SHALL be 00 outside a resolving IDLE cycle.

Reset
REQ-018 reset SHALL asynchronously force state IDLE, counter 0, and all outputs 0, including mid-STALL and in the redirect cycle.

Configuration
REQ-019 With BRANCH_STATS_EN defined, the counters SHALL count:
- stat_branches: resolved branches
- stat_taken: redirects
- stat_stalls: stall cycles
Counters SHALL wrap at 2^CNT_W and clear on reset. Without the macro, the counter ports SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-020 A shared package SHALL hold the opcode/REGIMM constants, the fwd-select encoding, and the FSM state enum.
REQ-021 Target computation SHALL be the sub-module branch_target (combinational).

Verification
REQ-022 Directed scenarios:
- BEQ pc=0x100, imm=0x0004, cmp_taken=1, no hazard -> same cycle redirect_valid=1, redirect_pc=0x114; next valid instruction gives no redirect.
- BNE rs=5, EX is a load to r5 -> stall=1 for 2 cycles; then resolve, fwd_a_sel=00.
- BGTZ rs=3, EX is an ALU write to r3 -> 1 stall cycle; next cycle fwd_a_sel=10 when r3 is a non-load in MEM.
- JR op_a=0x8000_0040 -> redirect_pc=0x8000_0040; branch in delay slot -> no redirect.
- reset asserted mid-STALL -> stall=0 immediately; state IDLE.
- BRANCH_STATS_EN: 3 branches, 2 taken, 1 stall cycle -> counters 3/2/1; without the macro -> counters 0.
